shift_arbiter: RTL

Shares the ALU's single 32-bit logical right-shift datapath (`right_shift`: ports `A`, `shamt`, `result`) between two requesters, e.g. the integer issue port and the address/immediate unit.

- Arbitrates requests with round-robin priority.
- Maps SRL, SLL and SRA onto the one right-shift instance, using bit reversal for SLL and sign fill for SRA.
- Returns each result through a one-deep registered output stage with a valid/ready handshake and a requester ID tag.

---
 rtl/shift_arbiter_if.sv | 31 +++
 rtl/shift_arbiter.sv | 53 +++++
 2 files changed

// File: rtl/shift_arbiter_if.sv
// shift_arbiter_if: bundles both requester ports (valid/ready/op/a/shamt) and the result port (valid/ready/id/data); master = requesters+consumer side, slave = arbiter
interface shift_arbiter_if #(parameter int WIDTH = 32);
  logic             req0_valid;
  logic             req0_ready;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [4:0]       req0_shamt;
  logic             req1_valid;
  logic             req1_ready;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [4:0]       req1_shamt;
  logic             out_valid;
  logic             out_ready;
  logic             out_id;
  logic [WIDTH-1:0] out_data;
  modport master (
    output req0_valid, req0_op, req0_a, req0_shamt,
    output req1_valid, req1_op, req1_a, req1_shamt,
    input  req0_ready, req1_ready,
    input  out_valid, out_id, out_data,
    output out_ready
  );
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_shamt,
    input  req1_valid, req1_op, req1_a, req1_shamt,
    output req0_ready, req1_ready,
    output out_valid, out_id, out_data,
    input  out_ready
  );
endinterface

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin share of one right shifter (SRL/SLL/SRA) between two requesters; ports clk, rst_n (async low), bus (shift_arbiter_if.slave: req0/req1 valid-ready requests, registered out valid-ready result with id tag)
module right_shift (
  input  logic [31:0] A,
  input  logic [4:0]  shamt,
  output logic [31:0] result
);
  assign result = A >> shamt;
endmodule

module shift_arbiter #(parameter int WIDTH = 32) (
  input logic          clk,
  input logic          rst_n,
  shift_arbiter_if.slave bus
);
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] x);
    for (int i = 0; i < WIDTH; i++) rev[i] = x[WIDTH-1-i];
  endfunction
  logic             cap, g0, g1, prio;
  logic [1:0]       op;
  logic [WIDTH-1:0] a, sh_in, sh_out, res;
  logic [4:0]       s;
  assign cap = !bus.out_valid || bus.out_ready;
  assign g0  = rst_n && cap && bus.req0_valid && (!bus.req1_valid || !prio);
  assign g1  = rst_n && cap && bus.req1_valid && (!bus.req0_valid || prio);
  assign bus.req0_ready = g0;
  assign bus.req1_ready = g1;
  always_comb begin
    op    = g1 ? bus.req1_op : bus.req0_op;
    a     = g1 ? bus.req1_a : bus.req0_a;
    s     = g1 ? bus.req1_shamt : bus.req0_shamt;
    sh_in = op == OP_SLL ? rev(a) : a;
    res   = op == OP_SLL ? rev(sh_out) :
            (op == OP_SRA && a[WIDTH-1]) ? sh_out | ~({WIDTH{1'b1}} >> s) : sh_out;
  end
  right_shift u_shift (.A(sh_in), .shamt(s), .result(sh_out));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_id    <= 1'b0;
      bus.out_data  <= '0;
      prio          <= 1'b0;
    end else if (g0 || g1) begin
      bus.out_valid <= 1'b1;
      bus.out_id    <= g1;
      bus.out_data  <= res;
      prio          <= g0;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule
